// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared commands, FSM states and port selection for sram_arbiter
package sram_arb_pkg;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

  typedef logic port_idx_t;

  // A tie goes to the port that did not own the previous command.
  function automatic port_idx_t pick_port(input logic [1:0] pend, input port_idx_t last);
    if (pend == 2'b11) return ~last;
    return pend[1];
  endfunction

endpackage

// File: rtl/sram_arb_port.sv
// rtl/sram_arb_port.sv - per-requester capture register, pending flag and rdata holding
module sram_arb_port
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          cmd,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                owned,
  input  logic                complete,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                pending,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic [7:0]          hold_cmd,
  output logic [ADDR_W-1:0]   hold_addr,
  output logic [DATA_W-1:0]   hold_wdata,
  output logic [DATA_W/8-1:0] hold_wstrb
);

  assign busy = pending | owned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      hold_cmd   <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_wstrb <= '0;
    end else begin
      done <= complete;
      // complete implies busy, so a start in the completing cycle is dropped here.
      if (complete) begin
        pending <= 1'b0;
        rdata   <= sram_rdata;
      end else if (start && !busy) begin
        pending    <= 1'b1;
        hold_cmd   <= cmd;
        hold_addr  <= addr;
        hold_wdata <= wdata;
        hold_wstrb <= wstrb;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-port arbiter in front of sram_proc_new; SRAM_ARB_STATS_EN adds grant/conflict counters
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_start,
  input  logic [7:0]          req0_cmd,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_wstrb,
  output logic                req0_busy,
  output logic                req0_done,
  output logic [DATA_W-1:0]   req0_rdata,
  input  logic                req1_start,
  input  logic [7:0]          req1_cmd,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_wstrb,
  output logic                req1_busy,
  output logic                req1_done,
  output logic [DATA_W-1:0]   req1_rdata,
  output logic                sram_start,
  input  logic                sram_busy,
  input  logic                sram_done,
  output logic [7:0]          sram_cmd,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wstrb,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                grant
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_grants0,
  output logic [31:0]         stat_grants1,
  output logic [15:0]         stat_conflicts
`endif
);

  arb_state_t state;
  port_idx_t  last_grant;
  port_idx_t  sel;
  logic [1:0] pend;
  logic [1:0] owned;
  logic [1:0] complete;

  logic [7:0]          hold_cmd   [2];
  logic [ADDR_W-1:0]   hold_addr  [2];
  logic [DATA_W-1:0]   hold_wdata [2];
  logic [DATA_W/8-1:0] hold_wstrb [2];

  assign owned[0]    = (state == ST_WAIT) && (grant == 1'b0);
  assign owned[1]    = (state == ST_WAIT) && (grant == 1'b1);
  assign complete[0] = owned[0] && sram_done;
  assign complete[1] = owned[1] && sram_done;
  assign sel         = pick_port(pend, last_grant);

  sram_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port0 (
    .clk        (clk),
    .reset      (reset),
    .start      (req0_start),
    .cmd        (req0_cmd),
    .addr       (req0_addr),
    .wdata      (req0_wdata),
    .wstrb      (req0_wstrb),
    .owned      (owned[0]),
    .complete   (complete[0]),
    .sram_rdata (sram_rdata),
    .pending    (pend[0]),
    .busy       (req0_busy),
    .done       (req0_done),
    .rdata      (req0_rdata),
    .hold_cmd   (hold_cmd[0]),
    .hold_addr  (hold_addr[0]),
    .hold_wdata (hold_wdata[0]),
    .hold_wstrb (hold_wstrb[0])
  );

  sram_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
    .clk        (clk),
    .reset      (reset),
    .start      (req1_start),
    .cmd        (req1_cmd),
    .addr       (req1_addr),
    .wdata      (req1_wdata),
    .wstrb      (req1_wstrb),
    .owned      (owned[1]),
    .complete   (complete[1]),
    .sram_rdata (sram_rdata),
    .pending    (pend[1]),
    .busy       (req1_busy),
    .done       (req1_done),
    .rdata      (req1_rdata),
    .hold_cmd   (hold_cmd[1]),
    .hold_addr  (hold_addr[1]),
    .hold_wdata (hold_wdata[1]),
    .hold_wstrb (hold_wstrb[1])
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      sram_start <= 1'b0;
      sram_cmd   <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_wstrb <= '0;
`ifdef SRAM_ARB_STATS_EN
      stat_grants0   <= '0;
      stat_grants1   <= '0;
      stat_conflicts <= '0;
`endif
    end else begin
      sram_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((pend != 2'b00) && !sram_busy) begin
            sram_cmd   <= hold_cmd[sel];
            sram_addr  <= hold_addr[sel];
            sram_wdata <= hold_wdata[sel];
            sram_wstrb <= hold_wstrb[sel];
            sram_start <= 1'b1;
            grant      <= sel;
            state      <= ST_WAIT;
`ifdef SRAM_ARB_STATS_EN
            if (sel == 1'b1) stat_grants1 <= stat_grants1 + 32'd1;
            else             stat_grants0 <= stat_grants0 + 32'd1;
            if ((pend == 2'b11) && (stat_conflicts != 16'hFFFF))
              stat_conflicts <= stat_conflicts + 16'd1;
`endif
          end
        end
        ST_WAIT: begin
          // Command fields stay frozen until the engine reports completion.
          if (sram_done) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed table-driven bench for sram_arbiter
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_start = 1'b0, req1_start = 1'b0;
  logic [7:0]  req0_cmd = '0, req1_cmd = '0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_wdata = '0, req1_wdata = '0;
  logic [3:0]  req0_wstrb = '0, req1_wstrb = '0;
  logic        req0_busy, req1_busy, req0_done, req1_done;
  logic [31:0] req0_rdata, req1_rdata;
  logic        sram_start, sram_busy = 1'b0, sram_done = 1'b0;
  logic [7:0]  sram_cmd;
  logic [31:0] sram_addr, sram_wdata, sram_rdata = '0;
  logic [3:0]  sram_wstrb;
  logic        grant;
`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stat_grants0, stat_grants1;
  logic [15:0] stat_conflicts;
`endif

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_start(req0_start), .req0_cmd(req0_cmd), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb), .req0_busy(req0_busy),
    .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req1_start(req1_start), .req1_cmd(req1_cmd), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb), .req1_busy(req1_busy),
    .req1_done(req1_done), .req1_rdata(req1_rdata),
    .sram_start(sram_start), .sram_busy(sram_busy), .sram_done(sram_done),
    .sram_cmd(sram_cmd), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata), .grant(grant)
`ifdef SRAM_ARB_STATS_EN
    , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1),
    .stat_conflicts(stat_conflicts)
`endif
  );

  typedef struct {
    int          port;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rd;
    logic        exp_grant;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [4];
  int checks = 0, errors = 0;
  int start_cnt = 0, done0_cnt = 0, done1_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (sram_start) start_cnt++;
    if (req0_done) done0_cnt++;
    if (req1_done) done1_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic busy_of(input int p);
    return (p == 1) ? req1_busy : req0_busy;
  endfunction

  function automatic logic done_of(input int p);
    return (p == 1) ? req1_done : req0_done;
  endfunction

  function automatic logic [31:0] rdata_of(input int p);
    return (p == 1) ? req1_rdata : req0_rdata;
  endfunction

  task automatic drive_req(input int p, input logic [7:0] c, input logic [31:0] a,
                           input logic [31:0] w, input logic [3:0] s);
    if (p == 1) begin
      req1_start = 1'b1; req1_cmd = c; req1_addr = a; req1_wdata = w; req1_wstrb = s;
    end else begin
      req0_start = 1'b1; req0_cmd = c; req0_addr = a; req0_wdata = w; req0_wstrb = s;
    end
  endtask

  task automatic pulse_req(input int p, input logic [7:0] c, input logic [31:0] a,
                           input logic [31:0] w, input logic [3:0] s);
    drive_req(p, c, a, w, s);
    @(negedge clk);
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic wait_start();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sram_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("start_timeout", ok, 1'b1);
  endtask

  task automatic serve(input logic [31:0] rd, output logic g, output logic [31:0] a);
    wait_start();
    g = grant;
    a = sram_addr;
    @(negedge clk);
    sram_done = 1'b1;
    sram_rdata = rd;
    @(negedge clk);
    sram_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    pulse_req(v.port, v.cmd, v.addr, v.wdata, v.wstrb);
    chk("busy_after_capture", busy_of(v.port), 1'b1);
    chk("start_not_early", sram_start, 1'b0);
    @(negedge clk);
    chk("start_pulse", sram_start, 1'b1);
    chk("sram_cmd", sram_cmd, v.cmd);
    chk("sram_addr", sram_addr, v.addr);
    chk("sram_wdata", sram_wdata, v.wdata);
    chk("sram_wstrb", sram_wstrb, v.wstrb);
    chk("grant", grant, v.exp_grant);
    @(negedge clk);
    chk("start_one_cycle", sram_start, 1'b0);
    chk("addr_held", sram_addr, v.addr);
    sram_done = 1'b1;
    sram_rdata = v.rd;
    @(negedge clk);
    sram_done = 1'b0;
    chk("done_pulse", done_of(v.port), 1'b1);
    chk("other_done_quiet", done_of(1 - v.port), 1'b0);
    chk("rdata", rdata_of(v.port), v.exp_rdata);
    @(negedge clk);
    chk("done_one_cycle", done_of(v.port), 1'b0);
    chk("busy_cleared", busy_of(v.port), 1'b0);
  endtask

  initial begin
    logic        g;
    logic [31:0] a;
    int          s0, d0, d1;

    vecs[0] = '{0, CMD_READ,  32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1, CMD_WRITE, 32'h0000_0204, 32'hCAFE_F00D, 4'h3, 32'h1234_5678, 1'b1, 32'h1234_5678};
    vecs[2] = '{0, CMD_WRITE, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0, 32'h0};
    vecs[3] = '{1, CMD_READ,  32'h0000_0000, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sram_start", sram_start, 1'b0);
    chk("rst_sram_cmd", sram_cmd, 8'h0);
    chk("rst_sram_addr", sram_addr, 32'h0);
    chk("rst_sram_wdata", sram_wdata, 32'h0);
    chk("rst_sram_wstrb", sram_wstrb, 4'h0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_busy0", req0_busy, 1'b0);
    chk("rst_busy1", req1_busy, 1'b0);
    chk("rst_done0", req0_done, 1'b0);
    chk("rst_done1", req1_done, 1'b0);
    chk("rst_rdata0", req0_rdata, 32'h0);
    chk("rst_rdata1", req1_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single-port transactions
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Simultaneous requests; last owner was port 1, so port 0 goes first
    s0 = start_cnt;
    drive_req(0, CMD_WRITE, 32'h0000_0400, 32'h1122_3344, 4'hF);
    drive_req(1, CMD_READ,  32'h0000_0200, 32'h0, 4'h0);
    @(negedge clk);
    req0_start = 1'b0;
    req1_start = 1'b0;
    wait_start();
    chk("sim_wdata", sram_wdata, 32'h1122_3344);
    chk("sim_wstrb", sram_wstrb, 4'hF);
    serve(32'h0000_0055, g, a);
    chk("sim_grant_first", g, 1'b0);
    chk("sim_addr_first", a, 32'h0000_0400);
    serve(32'h0000_0066, g, a);
    chk("sim_grant_second", g, 1'b1);
    chk("sim_addr_second", a, 32'h0000_0200);
    repeat (3) @(negedge clk);
    chk("sim_start_count", start_cnt - s0, 2);
    chk("sim_rdata0", req0_rdata, 32'h0000_0055);
    chk("sim_rdata1", req1_rdata, 32'h0000_0066);

    // Continuous requesting from both ports
    drive_req(0, CMD_READ, 32'h0000_1000, 32'h0, 4'h0);
    drive_req(1, CMD_READ, 32'h0000_2000, 32'h0, 4'h0);
    @(negedge clk);
    req0_start = 1'b0;
    req1_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int ep;
      ep = i % 2;
      serve(32'h100 + i, g, a);
      chk("rr_grant", g, ep[0]);
      chk("rr_addr", a, (ep == 1 ? 32'h2000 : 32'h1000) + (i / 2) * 4);
      if (i < 4)
        pulse_req(ep, CMD_READ, (ep == 1 ? 32'h2000 : 32'h1000) + ((i / 2) + 1) * 4, 32'h0, 4'h0);
    end
    repeat (3) @(negedge clk);
    chk("rr_idle_busy0", req0_busy, 1'b0);
    chk("rr_idle_busy1", req1_busy, 1'b0);

    // Starts while busy, including one aligned with sram_done, are dropped
    s0 = start_cnt;
    d1 = done1_cnt;
    pulse_req(1, CMD_READ, 32'h0000_0300, 32'h0, 4'h0);
    pulse_req(1, CMD_READ, 32'h0000_03FC, 32'h0, 4'h0);
    wait_start();
    chk("ign_addr", sram_addr, 32'h0000_0300);
    @(negedge clk);
    sram_done = 1'b1;
    sram_rdata = 32'h7777_0000;
    drive_req(1, CMD_READ, 32'h0000_03F8, 32'h0, 4'h0);
    @(negedge clk);
    sram_done = 1'b0;
    req1_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("ign_start_count", start_cnt - s0, 1);
    chk("ign_done_count", done1_cnt - d1, 1);
    chk("ign_busy1", req1_busy, 1'b0);
    chk("ign_rdata1", req1_rdata, 32'h7777_0000);

    // External sram_busy holds off issue
    sram_busy = 1'b1;
    s0 = start_cnt;
    pulse_req(0, CMD_READ, 32'h0000_0500, 32'h0, 4'h0);
    repeat (5) @(negedge clk);
    chk("sbusy_no_start", start_cnt - s0, 0);
    chk("sbusy_pending", req0_busy, 1'b1);
    sram_busy = 1'b0;
    @(negedge clk);
    chk("sbusy_release_start", sram_start, 1'b1);
    serve(32'h0000_0505, g, a);
    chk("sbusy_addr", a, 32'h0000_0500);

    // Reset during WAIT, then a stray sram_done
    pulse_req(1, CMD_WRITE, 32'h0000_0600, 32'h6666_6666, 4'hF);
    wait_start();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    s0 = start_cnt;
    d0 = done0_cnt;
    d1 = done1_cnt;
    sram_done = 1'b1;
    @(negedge clk);
    sram_done = 1'b0;
    chk("rstw_done1", req1_done, 1'b0);
    chk("rstw_busy1", req1_busy, 1'b0);
    chk("rstw_busy0", req0_busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("rstw_done_counts", (done0_cnt - d0) + (done1_cnt - d1), 0);
    chk("rstw_no_start", start_cnt - s0, 0);
    chk("rstw_addr", sram_addr, 32'h0);

`ifdef SRAM_ARB_STATS_EN
    chk("stat_rst_g0", stat_grants0, 32'd0);
    chk("stat_rst_g1", stat_grants1, 32'd0);
    chk("stat_rst_conf", stat_conflicts, 16'd0);
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    run_vec(vecs[0]);
    chk("stat_g0", stat_grants0, 32'd3);
    chk("stat_g1", stat_grants1, 32'd2);
    chk("stat_conf", stat_conflicts, 16'd0);
    drive_req(0, CMD_READ, 32'h0000_0700, 32'h0, 4'h0);
    drive_req(1, CMD_READ, 32'h0000_0800, 32'h0, 4'h0);
    @(negedge clk);
    req0_start = 1'b0;
    req1_start = 1'b0;
    serve(32'h1, g, a);
    serve(32'h2, g, a);
    @(negedge clk);
    chk("stat_g0_pair", stat_grants0, 32'd4);
    chk("stat_g1_pair", stat_grants1, 32'd3);
    chk("stat_conf_pair", stat_conflicts, 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
